adpcm_decoder: RTL and testbench

Sequential IMA-ADPCM decoder. It accepts 4-bit codes from the compressor's code stream and rebuilds 16-bit signed PCM samples. It is the receive-side counterpart of the PDM→CIC→ADPCM compressor, used for loopback checking and for playback. The step-size multiply is done as a shift-add over several cycles to keep area small, and one code is accepted per decode through a valid/ready handshake.

---
 rtl/adpcm_decoder.sv | 137 +++++++++++++
 tb/tb_adpcm_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_decoder.sv
// Sequential IMA-ADPCM decoder: one 4-bit code in, one saturated 16-bit PCM sample out.
// The step multiply is a shift-add spread over states B2/B1/B0, with the predictor update in UPD.
module adpcm_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        block_enable,
  input  logic [3:0]  encPcm,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] pcmOut,
  output logic        outValid,
  output logic [2:0]  dbg_state
);

  // Handshake: a code transfers on a rising edge where inValid && inReady are both high;
  // the sender holds encPcm stable until then, and inValid outside IDLE has no effect.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B2   = 3'd1,
    S_B1   = 3'd2,
    S_B0   = 3'd3,
    S_UPD  = 3'd4
  } state_t;

  localparam logic [14:0] STEP [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  state_t              state;
  state_t              state_nxt;
  logic signed [15:0]  predictor;
  logic [6:0]          index;
  logic [14:0]         step_r;
  logic [14:0]         step_now;
  logic [3:0]          code;
  logic [15:0]         diff;
  logic                accept;
  logic signed [17:0]  sum;
  logic [15:0]         sat;
  logic signed [4:0]   adj;
  logic signed [8:0]   idx_sum;
  logic [6:0]          idx_clamp;

  assign accept   = inValid && inReady;
  assign step_now = STEP[index];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_B2;
      S_B2:    state_nxt = S_B1;
      S_B1:    state_nxt = S_B0;
      S_B0:    state_nxt = S_UPD;
      S_UPD:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inReady   = (state == S_IDLE) && block_enable;
    dbg_state = state;
  end

  // 18-bit signed sum leaves headroom for predictor +/- a 16-bit unsigned diff.
  always_comb begin
    if (code[3]) sum = $signed({{2{predictor[15]}}, predictor}) - $signed({2'b00, diff});
    else         sum = $signed({{2{predictor[15]}}, predictor}) + $signed({2'b00, diff});
    if (sum > 18'sd32767)       sat = 16'h7fff;
    else if (sum < -18'sd32768) sat = 16'h8000;
    else                        sat = sum[15:0];
  end

  always_comb begin
    case (code[2:0])
      3'd4:    adj = 5'sd2;
      3'd5:    adj = 5'sd4;
      3'd6:    adj = 5'sd6;
      3'd7:    adj = 5'sd8;
      default: adj = -5'sd1;
    endcase
    idx_sum = $signed({2'b00, index}) + $signed({{4{adj[4]}}, adj});
    if (idx_sum < 9'sd0)       idx_clamp = 7'd0;
    else if (idx_sum > 9'sd88) idx_clamp = 7'd88;
    else                       idx_clamp = idx_sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      predictor <= '0;
      index     <= '0;
      step_r    <= '0;
      code      <= '0;
      diff      <= '0;
      pcmOut    <= '0;
      outValid  <= 1'b0;
    end else begin
      outValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            code   <= encPcm;
            step_r <= step_now;
            diff   <= {4'b0000, step_now[14:3]};
          end
        end
        S_B2: if (code[2]) diff <= diff + {1'b0, step_r};
        S_B1: if (code[1]) diff <= diff + {2'b00, step_r[14:1]};
        S_B0: if (code[0]) diff <= diff + {3'b000, step_r[14:2]};
        S_UPD: begin
          predictor <= sat;
          pcmOut    <= sat;
          index     <= idx_clamp;
          outValid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_decoder.sv
// Bench for adpcm_decoder: directed and randomized codes scored against a plain IMA-ADPCM
// reference model, with cycle-accurate checks of inReady, outValid and pcmOut.
module tb_adpcm_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        block_enable = 1'b1;
  logic [3:0]  enc_pcm = 4'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] pcm_out;
  logic        out_valid;
  logic [2:0]  dbg_state;

  adpcm_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .block_enable (block_enable),
    .encPcm       (enc_pcm),
    .inValid      (in_valid),
    .inReady      (in_ready),
    .pcmOut       (pcm_out),
    .outValid     (out_valid),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // counters and check task
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  // reference model
  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
    279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166,
    1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428,
    4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289,
    16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int adj_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  int m_pred = 0;
  int m_idx  = 0;

  function automatic int model_decode(input int c);
    int step;
    int diff;
    step = step_tab[m_idx];
    diff = step / 8;
    if ((c & 4) != 0) diff += step;
    if ((c & 2) != 0) diff += step / 2;
    if ((c & 1) != 0) diff += step / 4;
    if ((c & 8) != 0) m_pred -= diff;
    else              m_pred += diff;
    if (m_pred > 32767)  m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    m_idx += adj_tab[c & 7];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 88) m_idx = 88;
    return m_pred;
  endfunction

  // scoreboard: expected samples and the cycle each is due
  logic [15:0] exp_q[$];
  int          due_q[$];
  int          cyc = 0;
  int          busy_left = 0;
  int          accept_cnt = 0;
  int          ov_cnt = 0;
  int          exp_hold = 0;
  logic        exp_ov;

  always @(negedge clk) begin
    cyc++;
    check("in_ready", {31'd0, in_ready}, {31'd0, (busy_left == 0) && block_enable});
    exp_ov = (due_q.size() > 0) && (due_q[0] == cyc);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (out_valid === 1'b1) ov_cnt++;
    if (exp_ov) begin
      exp_hold = $signed(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    check("pcm_out", 32'($signed(pcm_out)), exp_hold);
    if (rst) begin
      m_pred = 0;
      m_idx = 0;
      exp_hold = 0;
      busy_left = 0;
      exp_q.delete();
      due_q.delete();
    end else if (in_valid && in_ready) begin
      accept_cnt++;
      busy_left = 4;
      exp_q.push_back(16'(model_decode(int'(enc_pcm))));
      due_q.push_back(cyc + 5);
    end else if (busy_left > 0) begin
      busy_left--;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] c);
    bit acc = 0;
    @(posedge clk); #1;
    enc_pcm  = c;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(input string tag, input int exp);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    else       check(tag, 32'($signed(pcm_out)), exp);
    @(posedge clk); #1;
  endtask

  int a0;
  int o0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_pcm", {16'd0, pcm_out}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);

    // code 0 from reset: diff 0, index clamps at 0
    send_code(4'h0);
    wait_out("code0", 0);

    // 0x7 then 0xF
    do_reset();
    send_code(4'h7);
    wait_out("code7", 11);
    send_code(4'hF);
    wait_out("codeF", -19);

    // saturation both ways
    do_reset();
    repeat (40) send_code(4'h7);
    repeat (8) @(posedge clk);
    #1 check("sat_pos", 32'($signed(pcm_out)), 32767);
    repeat (40) send_code(4'hF);
    repeat (8) @(posedge clk);
    #1 check("sat_neg", 32'($signed(pcm_out)), -32768);

    // inValid held high with changing codes: one acceptance per 5 cycles
    do_reset();
    a0 = accept_cnt;
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (50) begin
      enc_pcm = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("b2b_accepts", accept_cnt - a0, 10);
    repeat (8) @(posedge clk);

    // randomized codes with random idle gaps
    do_reset();
    repeat (80) begin
      send_code(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (8) @(posedge clk);

    // reset while in B1 discards the decode and clears predictor/index
    send_code(4'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pcm", {16'd0, pcm_out}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (6) @(posedge clk);
    send_code(4'h7);
    wait_out("post_rst", 11);

    // block_enable low: nothing accepted
    @(posedge clk); #1;
    a0 = accept_cnt;
    block_enable = 1'b0;
    in_valid = 1'b1;
    enc_pcm = 4'h5;
    repeat (10) @(posedge clk);
    #1 check("be_low_accepts", accept_cnt - a0, 0);

    // drop block_enable right after acceptance: decode still completes
    a0 = accept_cnt;
    o0 = ov_cnt;
    block_enable = 1'b1;
    @(posedge clk); #1;
    block_enable = 1'b0;
    repeat (12) @(posedge clk);
    #1 in_valid = 1'b0;
    check("be_drop_accepts", accept_cnt - a0, 1);
    check("be_drop_outputs", ov_cnt - o0, 1);
    block_enable = 1'b1;
    send_code(4'h2);
    repeat (8) @(posedge clk);

    #1 $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
